// File: rtl/mem_pkg.sv
// Shared access-size codes, default window base, FSM state type and beat helper
// for the memory initiator.
package mem_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_4WORD = 2'b01;
    localparam logic [1:0] SZ_8WORD = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b11;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;
    localparam logic [31:0] DEFAULT_MEM_BYTES = 32'h0010_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [4:0] beats_for(input logic [1:0] size);
        case (size)
            SZ_4WORD: beats_for = 5'd4;
            SZ_8WORD: beats_for = 5'd8;
            default:  beats_for = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_line_buf.sv
// 8 x 32-bit read line buffer: one word written per cycle by index, whole line
// cleared synchronously when a new request is accepted.
module mem_line_buf (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         we,
    input  logic [2:0]   idx,
    input  logic [31:0]  wdata,
    output logic [255:0] line
);

    logic [7:0][31:0] line_q;
    logic [7:0][31:0] line_d;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        line_d = line_q;
        if (clr) begin
            line_d = '0;
        end else if (we) begin
            line_d[idx] = wdata;
        end
    end

    // NOTE: this storage is reset because the line is visible on rsp_rdata and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/mem_initiator.sv
// Converts single-line client requests into word/burst cycles on a memory port.
// Define MEM_INIT_WR_BURST_EN to allow 4-word and 8-word writes; otherwise they are rejected.
module mem_initiator
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic [31:0] MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_rd_wr,
    input  logic [1:0]   req_size,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_rdata,
    output logic         rsp_err,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_data_in,
    output logic [1:0]   mem_access_size,
    output logic         mem_rd_wr,
    output logic         mem_enable,
    input  logic [31:0]  mem_data_out,
    input  logic         mem_busy
);

`ifdef MEM_INIT_WR_BURST_EN
    localparam bit WR_BURST_EN = 1'b1;
`else
    localparam bit WR_BURST_EN = 1'b0;
`endif

    state_e         state_q, state_d;
    logic [4:0]     beat_q, beat_d;
    logic           rd_wr_q, rd_wr_d;
    logic [1:0]     size_q, size_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           rd_pend_q, rd_pend_d;
    logic [2:0]     rd_idx_q, rd_idx_d;

    logic           accept;
    logic           issuing;
    logic           illegal;
    logic [4:0]     last_beat;
    logic [31:0]    cap_word;

    assign req_ready = (state_q == ST_IDLE) && !mem_busy;
    assign accept    = req_valid && req_ready;
    assign issuing   = (state_q == ST_ISSUE);
    assign last_beat = beats_for(size_q) - 5'd1;

    always_comb begin
        illegal = 1'b0;
        if ((req_addr < BASE_ADDR) || ((req_addr - BASE_ADDR) >= MEM_BYTES)) begin
            illegal = 1'b1;
        end
        if ((req_size != SZ_BYTE) && (req_addr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
        if (!WR_BURST_EN && !req_rd_wr && ((req_size == SZ_4WORD) || (req_size == SZ_8WORD))) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rd_wr_d = rd_wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_wr_d = req_rd_wr;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = illegal;
                    beat_d  = 5'd0;
                    state_d = illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The counter stops at the last beat and is rearmed for the next request.
                if (beat_q == last_beat) begin
                    beat_d  = 5'd0;
                    state_d = rd_wr_q ? ST_WAIT : ST_RESP;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            ST_WAIT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory returns beat k one cycle after it is issued; capture trails issue by one cycle.
    assign rd_pend_d = issuing && rd_wr_q;
    assign rd_idx_d  = beat_q[2:0];
    assign cap_word  = (size_q == SZ_BYTE) ? {24'h0, mem_data_out[7:0]} : mem_data_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= 5'd0;
            rd_wr_q   <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_wr_q   <= rd_wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    mem_line_buf u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .we    (rd_pend_q),
        .idx   (rd_idx_q),
        .wdata (cap_word),
        .line  (rsp_rdata)
    );

    assign mem_enable      = issuing;
    assign mem_addr        = issuing ? addr_q : 32'h0;
    assign mem_access_size = issuing ? size_q : 2'b00;
    assign mem_rd_wr       = issuing ? rd_wr_q : 1'b0;
    assign mem_data_in     = (issuing && !rd_wr_q) ? wdata_q[{beat_q[2:0], 5'd0} +: 32] : 32'h0;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8002_0000, first byte address of the memory window.
REQ-002 SHALL have parameter MEM_BYTES, default 32'h0010_0000, window size in bytes.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  client request present.
REQ-006 req_ready  output  1  initiator can accept a request.
REQ-007 req_rd_wr  input  1  1=read, 0=write.
REQ-008 req_size  input  2  access-size code from the shared package.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  256  write line; word k in bits [32k+31:32k].
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  client accepts response.
REQ-013 rsp_rdata  output  256  read line, same word packing as req_wdata.
REQ-014 rsp_err  output  1  request rejected, no memory access made.
REQ-015 mem_addr, mem_data_in, mem_access_size, mem_rd_wr, mem_enable  outputs  32/32/2/1/1  drive the memory port.
REQ-016 mem_data_out  input  32  memory read data; mem_busy  input  1  memory mid-burst.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On req_valid&&req_ready at edge E0, request fields SHALL be latched, rsp_rdata cleared, and state SHALL go to RESP with rsp_err=1 if the request is illegal, else to ISSUE.
REQ-019 Illegal: addr outside [BASE_ADDR, BASE_ADDR+MEM_BYTES), non-byte access with addr[1:0]!=0, or a burst write when write bursts are compiled out (REQ-031).
REQ-020 Beat count N SHALL be 1 for byte and word, 4 for 4-word, 8 for 8-word.
REQ-021 In ISSUE, mem_enable SHALL be 1 for exactly N consecutive cycles (E0..EN), with mem_addr, mem_access_size and mem_rd_wr held constant at the latched values.
REQ-022 Write beat k (0..N-1) SHALL present req_wdata word k on mem_data_in during cycle Ek..Ek+1; a write SHALL go to RESP at EN with no WAIT.
REQ-023 Read: WAIT SHALL last one cycle with mem_enable=0; word k SHALL be sampled from mem_data_out at edge E(k+2); rsp_valid SHALL rise after E(N+1). Word read latency is 2 cycles to rsp_valid.
REQ-024 A byte read SHALL zero-extend mem_data_out[7:0] into word 0 and ignore bits [31:8].
REQ-025 A 5-bit beat counter SHALL count 0..N-1 and SHALL not wrap.
REQ-026 In RESP, rsp_valid SHALL stay 1 and rsp_rdata/rsp_err stable until rsp_ready; on the handshake edge state SHALL return to IDLE. A new request is accepted no earlier than the following edge.
REQ-027 If mem_busy=1 while in IDLE, req_ready SHALL be 0.
REQ-028 In IDLE, WAIT and RESP, mem_enable, mem_addr, mem_data_in, mem_access_size and mem_rd_wr SHALL be 0.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE, and the beat counter, line buffer and all outputs SHALL be 0, except req_ready, which SHALL be 1 after release.
REQ-030 Reset mid-burst SHALL drop mem_enable immediately and discard the partial line; no response SHALL be produced.

Configuration
REQ-031 With MEM_INIT_WR_BURST_EN defined, 4-word and 8-word writes SHALL be issued per REQ-022; without it, they SHALL be rejected with rsp_err=1 and no memory cycle.

Structure
REQ-032 Package mem_pkg SHALL hold the access-size codes SZ_WORD=2'b00, SZ_4WORD=2'b01, SZ_8WORD=2'b10, SZ_BYTE=2'b11, the default BASE_ADDR, and the state enum typedef.
REQ-033 Sub-module mem_line_buf SHALL hold the 8x32 read line with word-indexed write enable and a synchronous clear.

Verification
REQ-034 Word read at 0x80020010, memory word 0xDEADBEEF -> one enable cycle; rsp_valid 2 cycles after accept; rsp_rdata[31:0]=0xDEADBEEF; rsp_err=0.
REQ-035 8-word read at 0x80020000 -> mem_enable high 8 cycles with mem_addr constant; rsp_rdata word k = mem[k]; rsp_valid after E9.
REQ-036 Byte read at 0x80020003 with memory returning 0xZZZZZZ5A -> rsp_rdata[31:0]=0x0000005A.
REQ-037 Word read at 0x80000000, then word write at 0x80020002 -> both give rsp_err=1, no mem_enable pulse.
REQ-038 4-word write of words 0x11,0x22,0x33,0x44 -> with the macro, data appears on consecutive beats and readback matches; without it, rsp_err=1.
REQ-039 Reset asserted during beat 3 of an 8-word read, and rsp_ready held low for 5 cycles in a separate run -> on reset, mem_enable drops at once, no rsp_valid, req_ready=1 after release; with rsp_ready low, rsp_valid and data stay stable and req_ready=0.
